fired_tag_fifo: RTL and testbench

Queue of tags for neurons that fired in the current timestep. The neuron update stage pushes tags in. The synaptic processing unit pops them through the fifo_empty / req_deq / src_tag handshake. Tag output is first-word-fall-through: the head tag is valid combinationally whenever the queue is non-empty, so the consumer can latch it in the same cycle it raises req_deq. A per-neuron pending bitmap drops any repeat of a tag within one timestep. A flush clears the queue and the bitmap at the timestep boundary.

---
 rtl/fired_tag_fifo.sv | 129 ++++++++++++
 tb/tb_fired_tag_fifo.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/fired_tag_fifo.sv
// fired_tag_fifo: queue of fired-neuron tags for one timestep, with duplicate suppression.
// Latency: an accepted tag is visible on src_tag the cycle after its enqueue edge; the head is first-word-fall-through.
// Backpressure: no ready signal. Enqueues arriving while full are dropped and set the sticky overflow flag.
//
// Ports:
//   clk, asyn_reset      - rising-edge clock; asynchronous active-high reset
//   flush                - synchronous clear of queue and pending bitmap (timestep boundary)
//   enq_valid, enq_tag   - fired tag from the neuron update stage
//   req_deq              - consumer pops the head this cycle (samples src_tag in the same cycle)
//   src_tag              - head entry (0 when empty)
//   fifo_empty/fifo_full - count == 0 / count == depth
//   count                - number of queued entries
//   dup_drop             - one-cycle pulse: previous cycle's enqueue was a repeat within this timestep
//   overflow, underflow  - sticky drop/empty-pop indicators, cleared only by reset
module fired_tag_fifo #(
  parameter int numneurons = 2,
  parameter int tagbits    = 1,
  parameter int depth      = 2,
  parameter int ptrbits    = 1
) (
  input  logic               clk,
  input  logic               asyn_reset,
  input  logic               flush,
  input  logic               enq_valid,
  input  logic [tagbits-1:0] enq_tag,
  input  logic               req_deq,
  output logic [tagbits-1:0] src_tag,
  output logic               fifo_empty,
  output logic               fifo_full,
  output logic [ptrbits:0]   count,
  output logic               dup_drop,
  output logic               overflow,
  output logic               underflow
);

  // The pending bitmap spans the whole tag space so any enq_tag value indexes
  // it safely; bits at or above numneurons are never set.
  localparam int                 tagspace = 1 << tagbits;
  localparam logic [tagbits:0]   tag_lim  = (tagbits+1)'(numneurons);
  localparam logic [ptrbits-1:0] ptr_last = ptrbits'(depth - 1);
  localparam logic [ptrbits:0]   cnt_full = (ptrbits+1)'(depth);

  logic [tagbits-1:0]  mem [depth];
  logic [ptrbits-1:0]  rd_ptr;
  logic [ptrbits-1:0]  wr_ptr;
  logic [ptrbits:0]    cnt;
  logic [tagspace-1:0] pending;

  logic not_empty;
  logic tag_in_range;
  logic tag_pending;
  logic enq_try;
  logic deq_ok;
  logic space_ok;
  logic enq_ok;

  // Explicit wrap so non-power-of-two depths cycle through 0..depth-1 only.
  function automatic logic [ptrbits-1:0] next_ptr(input logic [ptrbits-1:0] p);
    return (p == ptr_last) ? '0 : p + ptrbits'(1);
  endfunction

  assign not_empty    = (cnt != '0);
  assign tag_in_range = ({1'b0, enq_tag} < tag_lim);
  assign tag_pending  = pending[enq_tag];

  // enq_try: a legal tag is offered and no flush is in progress. The duplicate
  // test is applied before the space test, so a repeat seen while full only
  // raises dup_drop.
  assign enq_try  = enq_valid && !flush && tag_in_range;
  assign deq_ok   = req_deq && !flush && not_empty;
  // A full queue still accepts when the head leaves on the same edge. An empty
  // queue never bypasses: deq_ok is low there, so the enqueue alone lands.
  assign space_ok = (cnt != cnt_full) || deq_ok;
  assign enq_ok   = enq_try && !tag_pending && space_ok;

  always_ff @(posedge clk or posedge asyn_reset) begin
    if (asyn_reset) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      cnt       <= '0;
      pending   <= '0;
      dup_drop  <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (flush) begin
      // Sticky flags survive the timestep boundary.
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      cnt      <= '0;
      pending  <= '0;
      dup_drop <= 1'b0;
    end else begin
      dup_drop <= enq_try && tag_pending;
      if (enq_try && !tag_pending && !space_ok) begin
        overflow <= 1'b1;
      end
      if (req_deq && !not_empty) begin
        underflow <= 1'b1;
      end
      if (enq_ok) begin
        wr_ptr           <= next_ptr(wr_ptr);
        pending[enq_tag] <= 1'b1;
      end
      // Pending bits are left set on dequeue: a neuron fires at most once per
      // timestep, so only flush re-arms it.
      if (deq_ok) begin
        rd_ptr <= next_ptr(rd_ptr);
      end
      if (enq_ok && !deq_ok) begin
        cnt <= cnt + (ptrbits+1)'(1);
      end else if (deq_ok && !enq_ok) begin
        cnt <= cnt - (ptrbits+1)'(1);
      end
    end
  end

  // Storage has no reset; stale entries are masked by cnt.
  always_ff @(posedge clk) begin
    if (enq_ok) begin
      mem[wr_ptr] <= enq_tag;
    end
  end

  assign src_tag    = not_empty ? mem[rd_ptr] : '0;
  assign fifo_empty = !not_empty;
  assign fifo_full  = (cnt == cnt_full);
  assign count      = cnt;

endmodule

// File: tb/tb_fired_tag_fifo.sv
module tb_fired_tag_fifo;
  localparam int NN = 5;
  localparam int TB = 3;
  localparam int DP = 3;
  localparam int PB = 2;

  logic          clk;
  logic          asyn_reset;
  logic          flush;
  logic          enq_valid;
  logic [TB-1:0] enq_tag;
  logic          req_deq;
  logic [TB-1:0] src_tag;
  logic          fifo_empty;
  logic          fifo_full;
  logic [PB:0]   count;
  logic          dup_drop;
  logic          overflow;
  logic          underflow;

  fired_tag_fifo #(.numneurons(NN), .tagbits(TB), .depth(DP), .ptrbits(PB)) dut (
    .clk(clk), .asyn_reset(asyn_reset), .flush(flush),
    .enq_valid(enq_valid), .enq_tag(enq_tag), .req_deq(req_deq),
    .src_tag(src_tag), .fifo_empty(fifo_empty), .fifo_full(fifo_full),
    .count(count), .dup_drop(dup_drop), .overflow(overflow), .underflow(underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: the queue as a list of tags, a per-neuron "fired this
  // timestep" set, and the three flags.
  int mq[$];
  int sb[$];
  bit fired [NN];
  bit m_dup, m_ovf, m_unf;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_clear(input bit flags_too);
    mq.delete();
    for (int i = 0; i < NN; i++) fired[i] = 1'b0;
    m_dup = 1'b0;
    if (flags_too) begin
      m_ovf = 1'b0;
      m_unf = 1'b0;
      sb.delete();
    end
  endtask

  // One clock edge of behaviour, from the queue rules.
  task automatic model_step(input bit fl, input bit ev, input int tag, input bit rq);
    bit pop;
    if (fl) begin
      sb.delete();
      model_clear(1'b0);
      return;
    end
    pop   = rq && (mq.size() > 0);
    m_dup = 1'b0;
    if (rq && mq.size() == 0) m_unf = 1'b1;
    if (ev && tag < NN) begin
      if (fired[tag]) m_dup = 1'b1;
      else if (mq.size() < DP || pop) begin
        fired[tag] = 1'b1;
        mq.push_back(tag);
        sb.push_back(tag);
      end else m_ovf = 1'b1;
    end
    // Popping after the push is safe: an empty queue never pops.
    if (pop) void'(mq.pop_front());
  endtask

  task automatic check_state();
    chk("count", 32'(count), 32'(mq.size()));
    chk("fifo_empty", 32'(fifo_empty), 32'(mq.size() == 0));
    chk("fifo_full", 32'(fifo_full), 32'(mq.size() == DP));
    chk("dup_drop", 32'(dup_drop), 32'(m_dup));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("underflow", 32'(underflow), 32'(m_unf));
    if (mq.size() == 0) chk("src_tag_empty", 32'(src_tag), 32'd0);
    else chk("src_tag_head", 32'(src_tag), 32'(mq[0]));
  endtask

  task automatic cyc(input bit fl, input bit ev, input int tag, input bit rq);
    @(negedge clk);
    check_state();
    #1;
    flush     = fl;
    enq_valid = ev;
    enq_tag   = TB'(tag);
    req_deq   = rq;
    model_step(fl, ev, tag, rq);
  endtask

  // Reset asserted between edges; outputs must clear without a clock.
  task automatic do_reset();
    @(negedge clk);
    check_state();
    #2;
    flush = 1'b0; enq_valid = 1'b0; enq_tag = '0; req_deq = 1'b0;
    asyn_reset = 1'b1;
    #1;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_empty", 32'(fifo_empty), 32'd1);
    chk("rst_full", 32'(fifo_full), 32'd0);
    chk("rst_src_tag", 32'(src_tag), 32'd0);
    chk("rst_flags", {29'd0, dup_drop, overflow, underflow}, 32'd0);
    model_clear(1'b1);
    @(negedge clk);
    #1;
    asyn_reset = 1'b0;
  endtask

  // Monitor: just before each edge, a pop that the DUT will perform must
  // deliver the oldest accepted tag.
  initial begin
    forever begin
      @(negedge clk);
      #4;
      if (!asyn_reset && req_deq && !flush && !fifo_empty) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL pop_unexpected actual=%0d required=none at %0t", src_tag, $time);
        end else begin
          chk("pop_tag", 32'(src_tag), 32'(sb.pop_front()));
        end
      end
    end
  end

  initial begin
    flush = 1'b0; enq_valid = 1'b0; enq_tag = '0; req_deq = 1'b0;
    asyn_reset = 1'b1;
    model_clear(1'b1);
    #3;
    chk("init_count", 32'(count), 32'd0);
    chk("init_empty", 32'(fifo_empty), 32'd1);
    @(negedge clk);
    #1;
    asyn_reset = 1'b0;

    // Fill, overflow, wrap on a full queue with simultaneous pop, duplicate while full.
    cyc(0, 1, 1, 0);
    cyc(0, 1, 0, 0);
    cyc(0, 1, 2, 0);
    cyc(0, 1, 3, 0);
    cyc(0, 1, 3, 1);
    cyc(0, 1, 1, 0);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 0);
    do_reset();

    // Pop and push on an empty queue: no bypass, underflow survives flush.
    cyc(0, 1, 0, 1);
    cyc(1, 0, 0, 0);
    cyc(0, 0, 0, 0);
    // Out-of-range tag ignored, duplicate pulse, flush re-arms.
    cyc(0, 1, 6, 0);
    cyc(0, 1, 1, 0);
    cyc(0, 1, 1, 0);
    cyc(0, 1, 2, 0);
    cyc(1, 1, 3, 1);
    cyc(0, 1, 1, 0);
    cyc(0, 1, 2, 0);
    cyc(0, 0, 0, 0);
    do_reset();
    cyc(0, 1, 1, 0);
    cyc(0, 0, 0, 0);

    // Randomized traffic with occasional flushes and resets.
    for (int n = 0; n < 3000; n++) begin
      if (n % 400 == 399) do_reset();
      else cyc($urandom_range(0, 19) == 0, $urandom_range(0, 3) != 0,
               int'($urandom_range(0, 6)), $urandom_range(0, 1) == 1);
    end

    cyc(0, 0, 0, 0);
    @(negedge clk);
    check_state();
    chk("scoreboard_len", 32'(sb.size()), 32'(mq.size()));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
